pipe_stage_elastic: RTL and testbench

- Parametrised, handshaked pipeline stage register; the general successor to the fixed per-stage latches between IF/ID/EX/DM/WB.
- Carries an opaque payload (inst, results, rd, isWb packed by the instantiating stage) with valid/ready flow control, flush and optional skid buffering.
- Replaces ad-hoc stall inputs so a stage stalls by deasserting downstream ready.
- Also provides a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_stage_elastic.sv | 120 ++++++++++++
 tb/tb_pipe_stage_elastic.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Handshaked pipeline stage register carrying an opaque payload, with flush,
// optional two-entry skid buffering and a saturating stall-cycle counter.
module pipe_stage_elastic #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       SKID      = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              main_valid_reg, main_valid_next;
  logic [DATA_W-1:0] main_data_reg, main_data_next;
  logic              skid_valid_reg, skid_valid_next;
  logic [DATA_W-1:0] skid_data_reg, skid_data_next;
  logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
  logic              accept;
  logic              emit;

  assign accept = in_valid & in_ready;
  assign emit   = main_valid_reg & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      // in_ready depends only on state, which breaks the out_ready -> in_ready path.
      assign in_ready = ~skid_valid_reg;

      always_comb begin
        main_valid_next = main_valid_reg;
        main_data_next  = main_data_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        if (flush) begin
          main_valid_next = 1'b0;
          skid_valid_next = 1'b0;
        end else if (!main_valid_reg || emit) begin
          if (skid_valid_reg) begin
            // Older skid entry moves up first to keep FIFO order.
            main_valid_next = 1'b1;
            main_data_next  = skid_data_reg;
            skid_valid_next = accept;
            if (accept) begin
              skid_data_next = in_data;
            end
          end else begin
            main_valid_next = accept;
            if (accept) begin
              main_data_next = in_data;
            end
          end
        end else if (accept) begin
          skid_valid_next = 1'b1;
          skid_data_next  = in_data;
        end
      end
    end else begin : g_single
      assign in_ready = ~main_valid_reg | out_ready;

      always_comb begin
        main_valid_next = main_valid_reg;
        main_data_next  = main_data_reg;
        skid_valid_next = 1'b0;
        skid_data_next  = skid_data_reg;
        if (flush) begin
          main_valid_next = 1'b0;
        end else if (accept) begin
          main_valid_next = 1'b1;
          main_data_next  = in_data;
        end else if (emit) begin
          main_valid_next = 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (stall_cnt_clr) begin
      stall_cnt_next = '0;
    end else if (main_valid_reg && !out_ready && !flush && stall_cnt_reg != CNT_MAX) begin
      stall_cnt_next = stall_cnt_reg + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= RESET_VAL;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= RESET_VAL;
      stall_cnt_reg  <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_data_reg  <= main_data_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      stall_cnt_reg  <= stall_cnt_next;
    end
  end

  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;
  assign occupancy = {1'b0, main_valid_reg} + {1'b0, skid_valid_reg};
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: one single-register and one skid instance,
// each driven by directed and random stimulus against a FIFO reference model.
module tb_pipe_stage_elastic;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
  localparam logic [DW-1:0] RV = 32'hC0DE_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [1:0] done = 2'b00;

  task automatic check(input int inst, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL inst%0d %s: got 0x%0h required 0x%0h", inst, name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int SK = gi;

    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;
    logic          clr;

    logic [DW-1:0] exp_q[$];
    int sc = 0;
    int n_emit = 0;
    int max_occ = 0;

    pipe_stage_elastic #(
      .DATA_W   (DW),
      .SKID     (SK),
      .RESET_VAL(RV),
      .CNT_W    (CW)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .occupancy    (occupancy),
      .stall_cnt    (stall_cnt),
      .stall_cnt_clr(clr)
    );

    // Stimulus side: every accepted payload enters the expected FIFO at the edge.
    initial begin
      logic          a;
      logic [DW-1:0] d;
      forever begin
        @(negedge clk);
        a = !rst && in_valid && in_ready && !flush;
        d = in_data;
        @(posedge clk);
        if (a && !rst) exp_q.push_back(d);
      end
    end

    // Monitor: compares DUT state and emitted payloads with the FIFO model.
    initial begin
      int n;
      logic [DW-1:0] e;
      forever begin
        @(negedge clk);
        if (rst) begin
          exp_q.delete();
          sc = 0;
        end else begin
          n = exp_q.size();
          check(gi, "occupancy", occupancy, n);
          check(gi, "out_valid", out_valid, n != 0);
          check(gi, "in_ready", in_ready, (SK != 0) ? (n < 2) : (n == 0 || out_ready));
          check(gi, "stall_cnt", stall_cnt, sc);
          if (flush) begin
            exp_q.delete();
          end else if (n != 0 && out_ready) begin
            e = exp_q.pop_front();
            check(gi, "out_data", out_data, e);
            n_emit++;
          end
          if (clr) sc = 0;
          else if (n != 0 && !out_ready && !flush && sc < SAT) sc++;
          if (n > max_occ) max_occ = n;
        end
      end
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r,
                         input logic f, input logic c);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      clr       = c;
    endtask

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    // Offers base, base+1, ... holding each until accepted; out_ready low in [st_lo, st_hi].
    task automatic run_items(input logic [DW-1:0] base, input int cnt, input int ncyc,
                             input int st_lo, input int st_hi);
      int idx = 0;
      for (int c = 0; c < ncyc; c++) begin
        drive(idx < cnt, (idx < cnt) ? base + DW'(idx) : '0, !(c >= st_lo && c <= st_hi), 1'b0, 1'b0);
        @(negedge clk);
        if (in_valid && in_ready) idx++;
        step();
      end
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
      int e0;
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check(gi, "rst_out_data", out_data, RV);
      check(gi, "rst_in_ready", in_ready, 1'b1);
      check(gi, "rst_occupancy", occupancy, 0);

      e0 = n_emit;
      run_items(32'h1, 8, 14, -1, -1);
      check(gi, "stream_count", n_emit - e0, 8);
      check(gi, "stream_stall", stall_cnt, 0);

      drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
      step();
      max_occ = 0;
      e0 = n_emit;
      run_items(32'hA, 3, 12, 1, 3);
      check(gi, "bp_max_occ", max_occ, (SK != 0) ? 2 : 1);
      check(gi, "bp_count", n_emit - e0, 3);
      check(gi, "bp_stall", stall_cnt, 3);

      drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
      step();
      check(gi, "pre_flush_occ", occupancy, (SK != 0) ? 2 : 1);
      drive(1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check(gi, "flush_valid", out_valid, 1'b0);
      check(gi, "flush_occ", occupancy, 0);
      repeat (3) step();

      for (int c = 0; c < 400; c++) begin
        drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
              $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
        step();
      end
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      repeat (4) step();
      check(gi, "rand_drain", occupancy, 0);

      drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
      step();
      drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      repeat (20) step();
      check(gi, "sat_cnt", stall_cnt, SAT);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      step();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check(gi, "clr_cnt", stall_cnt, 0);
      step();
      check(gi, "resume_cnt", stall_cnt, 1);

      drive(1'b1, 32'h88, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check(gi, "pre_rst_occ", occupancy, (SK != 0) ? 2 : 1);
      #2 rst = 1'b1;
      #1;
      check(gi, "arst_valid", out_valid, 1'b0);
      check(gi, "arst_data", out_data, RV);
      check(gi, "arst_stall", stall_cnt, 0);
      check(gi, "arst_occ", occupancy, 0);
      step();
      rst = 1'b0;
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      repeat (3) step();
      done[gi] = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 20000 && done != 2'b11; c++) @(posedge clk);
    if (done != 2'b11) begin
      checks++;
      errors++;
      $display("FAIL timeout: done=%b required 11", done);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
